// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pkg
// Brief    : Shared width, NOP encoding and fetch-queue entry type.
// Revision : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    localparam int          c_XLEN      = 32;
    localparam logic [31:0] c_INSTR_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [c_XLEN-1:0] pc;
        logic [c_XLEN-1:0] instr;
    } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : fetch_queue
// Brief    : In-order synchronous FIFO of fetched {pc, instr} with flush.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  fetch_entry_t           i_push_data,
    input  logic                   i_pop,
    input  logic                   i_flush,
    output logic [$clog2(DEPTH):0] o_count,
    output fetch_entry_t           o_head,
    output logic                   o_full,
    output logic                   o_empty
);

    localparam int c_PW = $clog2(DEPTH);

    fetch_entry_t          r_mem [DEPTH];
    logic [c_PW-1:0]       r_wr_ptr;
    logic [c_PW-1:0]       r_rd_ptr;
    logic [c_PW:0]         r_count;

    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];
    assign o_full  = (r_count == (c_PW+1)'(DEPTH));
    assign o_empty = (r_count == '0);

    // Storage is cleared on reset so the head shows {0, NOP} out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i].pc    <= '0;
                r_mem[i].instr <= c_INSTR_NOP;
            end
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= r_wr_ptr + c_PW'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PW'(1);
            end
            if (i_push && !i_pop) begin
                r_count <= r_count + (c_PW+1)'(1);
            end else if (!i_push && i_pop) begin
                r_count <= r_count - (c_PW+1)'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage
// Brief    : PC owner, credit-limited imem requester and wrong-path discard.
//            Optional FETCH_PERF_EN adds redirect/stall/fetch counters.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          FQ_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pc_pause,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_instr
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_redirects,
    output logic [31:0] perf_stall_cycles,
    output logic [31:0] perf_fetched
`endif
);

    localparam int c_CW = $clog2(FQ_DEPTH) + 1;

    logic [31:0]     r_fetch_pc;
    logic [31:0]     r_resp_pc;
    logic [c_CW-1:0] r_in_flight;
    logic [c_CW-1:0] r_discard;
    logic [c_CW-1:0] w_count;
    logic [c_CW-1:0] w_in_flight_nxt;
    logic [c_CW-1:0] w_discard_nxt;
    logic [31:0]     w_target;
    logic            w_credit;
    logic            w_handshake;
    logic            w_drop;
    logic            w_push;
    logic            w_pop;
    logic            w_q_full;
    logic            w_q_empty;
    fetch_entry_t    w_head;
    fetch_entry_t    w_push_data;

    assign w_target    = redirect_pc & ~32'h3;
    assign w_credit    = ({1'b0, w_count} + {1'b0, r_in_flight}) < (c_CW+1)'(FQ_DEPTH);
    assign imem_req    = !rst && !redirect && w_credit;
    assign imem_addr   = r_fetch_pc;
    assign w_handshake = imem_req && imem_gnt;
    // A response in a redirect cycle belongs to the old path even if discard is 0.
    assign w_drop      = imem_rvalid && (redirect || (r_discard != '0));
    assign w_push      = imem_rvalid && !w_drop && !rst;
    assign id_valid    = !w_q_empty;
    assign w_pop       = id_valid && !pc_pause && !redirect;
    assign id_pc       = w_head.pc;
    assign id_instr    = w_head.instr;

    always_comb begin
        w_push_data.pc    = r_resp_pc;
        w_push_data.instr = imem_rdata;
    end

    always_comb begin
        w_in_flight_nxt = r_in_flight;
        if (w_handshake) begin
            w_in_flight_nxt = w_in_flight_nxt + c_CW'(1);
        end
        if (imem_rvalid && (r_in_flight != '0)) begin
            w_in_flight_nxt = w_in_flight_nxt - c_CW'(1);
        end
        w_discard_nxt = r_discard;
        if (imem_rvalid && (r_discard != '0)) begin
            w_discard_nxt = r_discard - c_CW'(1);
        end
    end

    // Everything still outstanding after a redirect was fetched down the old path.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc  <= RESET_PC;
            r_resp_pc   <= RESET_PC;
            r_in_flight <= '0;
            r_discard   <= '0;
        end else begin
            r_in_flight <= w_in_flight_nxt;
            if (redirect) begin
                r_fetch_pc <= w_target;
                r_resp_pc  <= w_target;
                r_discard  <= w_in_flight_nxt;
            end else begin
                r_discard <= w_discard_nxt;
                if (w_handshake) begin
                    r_fetch_pc <= r_fetch_pc + 32'd4;
                end
                if (w_push) begin
                    r_resp_pc <= r_resp_pc + 32'd4;
                end
            end
        end
    end

    fetch_queue #(
        .DEPTH (FQ_DEPTH)
    ) u_fetch_queue (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_push_data (w_push_data),
        .i_pop       (w_pop),
        .i_flush     (redirect),
        .o_count     (w_count),
        .o_head      (w_head),
        .o_full      (w_q_full),
        .o_empty     (w_q_empty)
    );

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(w_push && w_q_full && !w_pop));

`ifdef FETCH_PERF_EN
    logic [31:0] r_perf_redirects;
    logic [31:0] r_perf_stall_cycles;
    logic [31:0] r_perf_fetched;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_redirects    <= '0;
            r_perf_stall_cycles <= '0;
            r_perf_fetched      <= '0;
        end else begin
            if (redirect) begin
                r_perf_redirects <= r_perf_redirects + 32'd1;
            end
            if (pc_pause && id_valid) begin
                r_perf_stall_cycles <= r_perf_stall_cycles + 32'd1;
            end
            if (w_pop) begin
                r_perf_fetched <= r_perf_fetched + 32'd1;
            end
        end
    end

    assign perf_redirects    = r_perf_redirects;
    assign perf_stall_cycles = r_perf_stall_cycles;
    assign perf_fetched      = r_perf_fetched;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_stage
// Brief    : Self-checking bench for fetch_stage with an in-bench memory and
//            a program-order reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;
    import fetch_pkg::*;

    localparam logic [31:0] c_RESET_PC = 32'h0000_0000;
    localparam int          c_DEPTH    = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        pc_pause;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_instr;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_redirects;
    logic [31:0] perf_stall_cycles;
    logic [31:0] perf_fetched;
`endif

    fetch_stage #(
        .RESET_PC (c_RESET_PC),
        .FQ_DEPTH (c_DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pc_pause    (pc_pause),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .id_valid    (id_valid),
        .id_pc       (id_pc),
        .id_instr    (id_instr)
`ifdef FETCH_PERF_EN
        ,
        .perf_redirects    (perf_redirects),
        .perf_stall_cycles (perf_stall_cycles),
        .perf_fetched      (perf_fetched)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          wrong;
    } mreq_t;

    mreq_t        mq[$];
    fetch_entry_t wq[$];
    logic [31:0]  m_fetch_pc;
    logic [31:0]  exp_pc;
    logic [31:0]  prev_addr;
    bit           prev_stall;
    bit           prev_rst;
    bit           gnt_force_low;
    int           gnt_pct;
    int           lat_min;
    int           lat_max;
    int           last_due;
    int           cyc;
    int           checks;
    int           failures;
    int           m_redirects;
    int           m_stalls;
    int           m_pops;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: drive memory at the negedge, check, advance the model, clock.
    task automatic cycle();
        bit           hs;
        bit           pop;
        bit           resp;
        int           due;
        fetch_entry_t e;
        resp        = !rst && (mq.size() > 0) && (mq[0].due <= cyc);
        imem_rvalid = resp;
        imem_rdata  = resp ? word_of(mq[0].addr) : 32'hDEAD_BEEF;
        imem_gnt    = gnt_force_low ? 1'b0 : (int'($urandom_range(99)) < gnt_pct);
        #1;
        if (rst) begin
            chk("req_in_rst", 32'(imem_req), 32'd0);
        end else begin
            chk("imem_req", 32'(imem_req),
                32'(!redirect && ((wq.size() + mq.size()) < c_DEPTH)));
            chk("id_valid", 32'(id_valid), 32'(wq.size() > 0));
            if (wq.size() > 0) begin
                chk("id_pc", id_pc, wq[0].pc);
                chk("id_instr", id_instr, wq[0].instr);
            end
            if (imem_req) chk("imem_addr", imem_addr, m_fetch_pc);
            if (prev_stall && !redirect) begin
                chk("hold_req", 32'(imem_req), 32'd1);
                chk("hold_addr", imem_addr, prev_addr);
            end
            if (prev_rst) begin
                chk("rst_id_pc", id_pc, 32'd0);
                chk("rst_id_instr", id_instr, c_INSTR_NOP);
            end
        end
        hs         = imem_req && imem_gnt;
        pop        = (wq.size() > 0) && !pc_pause && !redirect;
        prev_stall = !rst && imem_req && !imem_gnt;
        prev_addr  = imem_addr;
        prev_rst   = rst;
        if (rst) begin
            mq.delete();
            wq.delete();
            m_fetch_pc  = c_RESET_PC;
            exp_pc      = c_RESET_PC;
            last_due    = cyc;
            m_redirects = 0;
            m_stalls    = 0;
            m_pops      = 0;
        end else begin
            if (pc_pause && (wq.size() > 0)) m_stalls++;
            if (pop) begin
                chk("seq_pc", wq[0].pc, exp_pc);
                exp_pc = exp_pc + 32'd4;
                void'(wq.pop_front());
                m_pops++;
            end
            if (resp) begin
                if (!mq[0].wrong && !redirect) begin
                    e.pc    = mq[0].addr;
                    e.instr = word_of(mq[0].addr);
                    wq.push_back(e);
                end
                void'(mq.pop_front());
            end
            if (hs) begin
                due = cyc + int'($urandom_range(lat_max, lat_min));
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                mq.push_back('{addr: imem_addr, due: due, wrong: 1'b0});
                m_fetch_pc = m_fetch_pc + 32'd4;
            end
            if (redirect) begin
                m_redirects++;
                wq.delete();
                foreach (mq[i]) mq[i].wrong = 1'b1;
                m_fetch_pc = redirect_pc & ~32'h3;
                exp_pc     = redirect_pc & ~32'h3;
            end
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic check_perf();
`ifdef FETCH_PERF_EN
        chk("perf_redirects", perf_redirects, 32'(m_redirects));
        chk("perf_stall_cycles", perf_stall_cycles, 32'(m_stalls));
        chk("perf_fetched", perf_fetched, 32'(m_pops));
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] held_addr;
        int          n;
        checks = 0; failures = 0; cyc = 0;
        rst = 1'b1; pc_pause = 1'b0; redirect = 1'b0; redirect_pc = '0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        gnt_force_low = 1'b0; gnt_pct = 100; lat_min = 1; lat_max = 1;
        m_fetch_pc = c_RESET_PC; exp_pc = c_RESET_PC; last_due = 0;
        prev_stall = 1'b0; prev_rst = 1'b0; prev_addr = '0;
        m_redirects = 0; m_stalls = 0; m_pops = 0;
        @(negedge clk);

        // Reset state and streaming with a 1-cycle always-granting memory
        repeat (2) cycle();
        rst = 1'b0;
        chk("reset_id_valid", 32'(id_valid), 32'd0);
        chk("reset_id_pc", id_pc, 32'd0);
        chk("reset_id_instr", id_instr, c_INSTR_NOP);
        chk("reset_addr", imem_addr, c_RESET_PC);
        repeat (12) cycle();
        check_perf();

        // Hold decode with a full queue
        pc_pause = 1'b1;
        n = 0;
        while (!((wq.size() == c_DEPTH) && (mq.size() == 0)) && n < 20) begin
            cycle(); n++;
        end
        chk("fill_timeout", 32'(n < 20), 32'd1);
        held_addr = id_pc;
        repeat (5) begin
            chk("pause_req", 32'(imem_req), 32'd0);
            chk("pause_id_pc", id_pc, held_addr);
            cycle();
        end
        pc_pause = 1'b0;
        repeat (8) cycle();

        // Redirect with two responses in flight
        lat_min = 3; lat_max = 3;
        n = 0;
        while (mq.size() != 2 && n < 20) begin cycle(); n++; end
        chk("inflight_timeout", 32'(n < 20), 32'd1);
        redirect = 1'b1; redirect_pc = 32'h0000_0100;
        cycle();
        redirect = 1'b0;
        n = 0;
        while (!id_valid && n < 20) begin cycle(); n++; end
        chk("redir_first_pc", id_pc, 32'h0000_0100);
        cycle();
        n = 0;
        while (!id_valid && n < 20) begin cycle(); n++; end
        chk("redir_second_pc", id_pc, 32'h0000_0104);
        lat_min = 1; lat_max = 1;
        redirect = 1'b1; redirect_pc = 32'h0000_0103;
        cycle();
        redirect = 1'b0;
        n = 0;
        while (!id_valid && n < 20) begin cycle(); n++; end
        chk("redir_unaligned_pc", id_pc, 32'h0000_0100);
        repeat (4) cycle();

        // Grant withheld for three cycles
        n = 0;
        while (!imem_req && n < 20) begin cycle(); n++; end
        gnt_force_low = 1'b1;
        held_addr = imem_addr;
        repeat (3) begin
            chk("gnt_low_req", 32'(imem_req), 32'd1);
            chk("gnt_low_addr", imem_addr, held_addr);
            cycle();
        end
        gnt_force_low = 1'b0;
        repeat (6) cycle();

        // Redirect and pause together on a full queue with nothing in flight
        pc_pause = 1'b1;
        n = 0;
        while (!((wq.size() == c_DEPTH) && (mq.size() == 0)) && n < 20) begin
            cycle(); n++;
        end
        redirect = 1'b1; redirect_pc = 32'h0000_2000;
        cycle();
        redirect = 1'b0;
        chk("flush_id_valid", 32'(id_valid), 32'd0);
        n = 0;
        while (!id_valid && n < 20) begin cycle(); n++; end
        chk("redir_latency", 32'(n), 32'(1 + 1 + 1 - 1));
        chk("redir_target_pc", id_pc, 32'h0000_2000);
        pc_pause = 1'b0;
        repeat (4) cycle();
        check_perf();

        // Reset mid-stream with responses pending
        lat_min = 1; lat_max = 3; gnt_pct = 70;
        n = 0;
        while (mq.size() == 0 && n < 20) begin cycle(); n++; end
        chk("pending_timeout", 32'(mq.size() > 0), 32'd1);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("midrst_id_valid", 32'(id_valid), 32'd0);
        chk("midrst_id_pc", id_pc, 32'd0);
        chk("midrst_id_instr", id_instr, c_INSTR_NOP);
        chk("midrst_addr", imem_addr, c_RESET_PC);
        check_perf();

        // Randomised traffic including wrap-around targets
        for (int k = 0; k < 400; k++) begin
            pc_pause = ($urandom_range(3) == 0);
            redirect = ($urandom_range(15) == 0);
            redirect_pc = ($urandom_range(3) == 0) ? 32'hFFFF_FFF4 + 32'($urandom_range(7))
                                                   : $urandom;
            gnt_pct = int'($urandom_range(100, 30));
            cycle();
        end
        redirect = 1'b0; pc_pause = 1'b0;
        repeat (10) cycle();
        check_perf();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
